// File: rtl/ula_pkg.sv
// Shared opcode and FSM state types for the sequential ALU (ula_seq / ula_iter).
package ula_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpMul  = 4'd2,
    OpDiv  = 4'd3,
    OpShl  = 4'd4,
    OpShr  = 4'd5,
    OpRol  = 4'd6,
    OpRor  = 4'd7,
    OpAnd  = 4'd8,
    OpOr   = 4'd9,
    OpXor  = 4'd10,
    OpNor  = 4'd11,
    OpNand = 4'd12,
    OpXnor = 4'd13,
    OpGt   = 4'd14,
    OpEq   = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Multiply and non-trivial divide go through the W-cycle iterative datapath.
  function automatic logic is_iter(input op_e op, input logic b_zero);
    return (op == OpMul) || ((op == OpDiv) && !b_zero);
  endfunction

endpackage

// File: rtl/ula_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per step.
// With ULA_SEQ_REMAINDER_EN defined, the divide remainder is returned in the upper half.
module ula_iter #(
  parameter int unsigned W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           step_i,
  input  logic           div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           last_o,
  output logic [2*W-1:0] res_o
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, m_q;
  logic          div_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    sum, shifted, diff;
  logic          ge;

  // hi:lo is the product register for mul and the remainder:quotient pair for div.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted = {hi_q, lo_q[W-1]};
    diff    = shifted - {1'b0, m_q};
    ge      = shifted >= {1'b0, m_q};
    if (div_q) begin
      hi_d = ge ? diff[W-1:0] : shifted[W-1:0];
      lo_d = {lo_q[W-2:0], ge};
    end else begin
      hi_d = sum[W:1];
      lo_d = {sum[0], lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= div_i ? a_i : b_i;
      m_q   <= div_i ? b_i : a_i;
      div_q <= div_i;
      cnt_q <= '0;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = (cnt_q == CW'(W - 1));

`ifdef ULA_SEQ_REMAINDER_EN
  assign res_o = {hi_d, lo_d};
`else
  assign res_o = div_q ? {{W{1'b0}}, lo_d} : {hi_d, lo_d};
`endif

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU with valid/ready handshake; mul/div take W extra cycles via ula_iter.
// Optional ULA_SEQ_REMAINDER_EN returns the divide remainder in S[2W-1:W].
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [3:0]     Sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W-1:0] S,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           Z,
  output logic           err
);

  state_e         state_q, state_d;
  logic [2*W-1:0] s_q, s_d, single_s, iter_s;
  logic           err_q, err_d, z_q, z_d, single_err;
  logic           accept, b_zero, start, step, last;
  logic [W:0]     sum_w, diff_w;
  op_e            op;

  assign op     = op_e'(Sel);
  assign b_zero = (B == '0);
  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = {1'b0, A} - {1'b0, B};

  always_comb begin
    single_s   = '0;
    single_err = 1'b0;
    case (op)
      OpAdd:   single_s = {{(W-1){1'b0}}, sum_w};
      OpSub:   single_s = {{(W-1){diff_w[W]}}, diff_w};
      OpDiv:   single_err = b_zero;
      OpShl:   single_s = {{W{1'b0}}, A[W-2:0], 1'b0};
      OpShr:   single_s = {{W{1'b0}}, 1'b0, A[W-1:1]};
      OpRol:   single_s = {{W{1'b0}}, A[W-2:0], A[W-1]};
      OpRor:   single_s = {{W{1'b0}}, A[0], A[W-1:1]};
      OpAnd:   single_s = {{W{1'b0}}, A & B};
      OpOr:    single_s = {{W{1'b0}}, A | B};
      OpXor:   single_s = {{W{1'b0}}, A ^ B};
      OpNor:   single_s = {{W{1'b0}}, ~(A | B)};
      OpNand:  single_s = {{W{1'b0}}, ~(A & B)};
      OpXnor:  single_s = {{W{1'b0}}, ~(A ^ B)};
      OpGt:    single_s = {{(2*W-1){1'b0}}, A > B};
      OpEq:    single_s = {{(2*W-1){1'b0}}, A == B};
      default: single_s = '0;
    endcase
  end

  assign out_valid = (state_q == StDone);
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    err_d   = err_q;
    z_d     = z_q;
    start   = 1'b0;
    step    = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (is_iter(op, b_zero)) begin
            state_d = StBusy;
            start   = 1'b1;
          end else begin
            state_d = StDone;
            s_d     = single_s;
            err_d   = single_err;
            z_d     = (single_s == '0);
          end
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        // in_ready is low here, so in_valid and operand changes are ignored.
        step = 1'b1;
        if (last) begin
          state_d = StDone;
          s_d     = iter_s;
          err_d   = 1'b0;
          z_d     = (iter_s == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      err_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      err_q   <= err_d;
      z_q     <= z_d;
    end
  end

  assign S   = s_q;
  assign Z   = z_q;
  assign err = err_q;

  ula_iter #(
    .W(W)
  ) u_iter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .step_i (step),
    .div_i  (op == OpDiv),
    .a_i    (A),
    .b_i    (B),
    .last_o (last),
    .res_o  (iter_s)
  );

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: directed cases, hold/overlap, reset-in-BUSY, random ops.
module tb_ula_seq;

  localparam int W = 8;

  logic           clk, rst_n;
  logic [W-1:0]   A, B;
  logic [3:0]     Sel;
  logic           in_valid, in_ready, out_valid, out_ready, Z, err;
  logic [2*W-1:0] S;

  ula_seq #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Sel      (Sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .S        (S),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (Z),
    .err      (err)
  );

  typedef struct {
    logic [2*W-1:0] s;
    logic           e;
    int             lat;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   ordy_rand = 0;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (ordy_rand) out_ready = ($urandom_range(3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model from the opcode table using plain integer arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [3:0] sel, output logic [2*W-1:0] s,
                                output logic e, output int lat);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint m  = longint'(1) << W;
    longint r  = 0;
    logic [W-1:0] t;
    e   = 1'b0;
    lat = 1;
    case (sel)
      4'd0: r = ua + ub;
      4'd1: begin
        r = ua - ub;
        if (r < 0) r += (longint'(1) << (2 * W));
      end
      4'd2: begin r = ua * ub; lat = W + 1; end
      4'd3: begin
        if (ub == 0) begin
          r = 0;
          e = 1'b1;
        end else begin
          r   = ua / ub;
          lat = W + 1;
`ifdef ULA_SEQ_REMAINDER_EN
          r += (ua % ub) * m;
`endif
        end
      end
      4'd4: r = (ua * 2) % m;
      4'd5: r = ua / 2;
      4'd6: r = (ua * 2) % m + ua / (m / 2);
      4'd7: r = ua / 2 + (ua % 2) * (m / 2);
      4'd8: begin t = a & b; r = longint'(t); end
      4'd9: begin t = a | b; r = longint'(t); end
      4'd10: begin t = a ^ b; r = longint'(t); end
      4'd11: begin t = ~(a | b); r = longint'(t); end
      4'd12: begin t = ~(a & b); r = longint'(t); end
      4'd13: begin t = ~(a ^ b); r = longint'(t); end
      4'd14: r = (ua > ub) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    s = r[2*W-1:0];
  endfunction

  // Offer an op; garbage with random in_valid is driven while the DUT is not ready.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                       input logic [2*W-1:0] es, input logic ee, input int lat,
                       output logic ovl);
    int   n = 0;
    exp_t x;
    ovl = 1'b0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      in_valid = 1'($urandom_range(1));
      A        = W'($urandom);
      B        = W'($urandom);
      Sel      = 4'($urandom);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      A        = a;
      B        = b;
      Sel      = sel;
      in_valid = 1'b1;
      ovl      = out_valid;
      x.s      = es;
      x.e      = ee;
      x.lat    = lat;
      x.acc    = cyc + 1;
      sb.push_back(x);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = W'($urandom);
      B        = W'($urandom);
      Sel      = 4'($urandom);
    end
  endtask

  task automatic issue_rand();
    logic [W-1:0]   a, b;
    logic [3:0]     sel;
    logic [2*W-1:0] es;
    logic           ee, ovl;
    int             lat;
    a   = W'($urandom);
    b   = ($urandom_range(7) == 0) ? '0 : W'($urandom);
    sel = 4'($urandom);
    model(a, b, sel, es, ee, lat);
    issue(a, b, sel, es, ee, lat, ovl);
  endtask

  // Monitor: latency on first presentation, values at handshake, stability while held.
  initial begin
    bit             seen = 0;
    bit             hold = 0;
    logic [2*W-1:0] hs;
    logic           he, hz;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_S", 64'(S), 64'(hs));
          chk("hold_err", 64'(err), 64'(he));
          chk("hold_Z", 64'(Z), 64'(hz));
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_result_valid", 64'(out_valid), 64'd0);
          end else begin
            if (!seen) begin
              chk("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
              seen = 1;
            end
            if (out_ready) begin
              chk("S", 64'(S), 64'(sb[0].s));
              chk("err", 64'(err), 64'(sb[0].e));
              chk("Z", 64'(Z), 64'(sb[0].s == '0));
              void'(sb.pop_front());
              seen = 0;
            end
          end
        end
        hold = out_valid && !out_ready;
        hs   = S;
        he   = err;
        hz   = Z;
      end
    end
  end

  initial begin
    logic ovl;
    int   n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Sel       = '0;

    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_S", 64'(S), 64'd0);
    chk("reset_Z", 64'(Z), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors with the consumer always ready.
    out_ready = 1'b1;
    issue(8'hFE, 8'hF5, 4'd0, 16'h01F3, 1'b0, 1, ovl);
    issue(8'h10, 8'h20, 4'd1, 16'hFFF0, 1'b0, 1, ovl);
    issue(8'hFF, 8'hFB, 4'd2, 16'hFA05, 1'b0, 9, ovl);
`ifdef ULA_SEQ_REMAINDER_EN
    issue(8'hEA, 8'h07, 4'd3, 16'h0321, 1'b0, 9, ovl);
`else
    issue(8'hEA, 8'h07, 4'd3, 16'h0021, 1'b0, 9, ovl);
`endif
    issue(8'hFF, 8'h00, 4'd3, 16'h0000, 1'b1, 1, ovl);
    issue(8'h81, 8'h00, 4'd6, 16'h0003, 1'b0, 1, ovl);
    issue(8'h81, 8'h00, 4'd7, 16'h00C0, 1'b0, 1, ovl);
    issue(8'h5A, 8'h5A, 4'd15, 16'h0001, 1'b0, 1, ovl);

    // Hold result for 5 cycles, then overlap release with a new op.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(8'hA5, 8'h0F, 4'd10, 16'h00AA, 1'b0, 1, ovl);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_S", 64'(S), 64'h00AA);
      chk("held_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(8'hF0, 8'h3C, 4'd8, 16'h0030, 1'b0, 1, ovl);
    chk("overlap_accept", 64'(ovl), 64'd1);
    repeat (3) @(negedge clk);

    // Reset during BUSY cycle 4 of a multiply: result must be discarded.
    issue(8'hFF, 8'hFB, 4'd2, 16'hFA05, 1'b0, 9, ovl);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_busy_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy_S", 64'(S), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_S", 64'(S), 64'd0);
    repeat (W + 4) @(negedge clk);
    chk("no_stale_result", 64'(out_valid), 64'd0);

    // Random operations with a randomly stalling consumer.
    ordy_rand = 1;
    for (int i = 0; i < 250; i++) issue_rand();
    @(posedge clk);
    ordy_rand = 0;
    #1 out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
